// File: rtl/packed_cfg_arbiter.sv
// packed_cfg_arbiter
// Shares one registered 5-bit config word between two requesters that use
// different field splits ({a[1:0],b[2:0]} and {a[2:0],b[1:0]}). A granted word
// is registered onto o and held for HOLD_CYCLES cycles before the next grant.
// Arbitration is round-robin unless PACKED_CFG_ARB_FIXED_PRIO_EN is defined,
// in which case requester 0 always wins a contention.
module packed_cfg_arbiter #(
    parameter logic [4:0] RESET_WORD  = 5'b11000,
    parameter int         HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_a,
    input  logic [2:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_a,
    input  logic [1:0] req1_b,
    output logic       req1_ready,
    output logic [4:0] o,
    output logic       o_src,
    output logic       o_update,
    output logic       o_busy
);

    // Counter load value: the FSM leaves HOLD on the edge after the counter
    // reaches zero, so loading N-1 yields exactly N busy cycles.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       ptr_reg;
    logic [4:0] o_reg;
    logic       o_src_reg;
    logic       o_update_reg;
    logic       o_busy_reg;

    logic [1:0] valid;
    logic [1:0] grant;
    logic [1:0] ready;
    logic [4:0] word [2];
    logic       take;
    logic       win_idx;
    logic [4:0] word_next;

    assign valid   = {req1_valid, req0_valid};
    // Field a always lands in the MSBs; the split point differs per requester.
    assign word[0] = {req0_a, req0_b};
    assign word[1] = {req1_a, req1_b};

    // Pick the winner among the valid requesters.
    always_comb begin
        grant = 2'b00;
`ifdef PACKED_CFG_ARB_FIXED_PRIO_EN
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
`else
        if (valid == 2'b11) begin
            // Contention: the side that did not win last time goes next.
            grant = ptr_reg ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
`endif
    end

    // Ready is only offered in IDLE and never while reset is asserted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = !rst && (state_reg == IDLE) && grant[gi];
        end
    endgenerate

    assign take      = |ready;
    assign win_idx   = ready[1];
    assign word_next = word[win_idx];

    // Arbiter FSM: register the granted word, then hold it for HOLD_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            ptr_reg      <= 1'b1;
            o_reg        <= RESET_WORD;
            o_src_reg    <= 1'b0;
            o_update_reg <= 1'b0;
            o_busy_reg   <= 1'b0;
        end else begin
            o_update_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        o_reg        <= word_next;
                        o_src_reg    <= win_idx;
                        o_update_reg <= 1'b1;
                        o_busy_reg   <= 1'b1;
                        cnt_reg      <= HOLD_LOAD;
                        ptr_reg      <= win_idx;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_reg == 4'd0) begin
                        o_busy_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    o_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign o          = o_reg;
    assign o_src      = o_src_reg;
    assign o_update   = o_update_reg;
    assign o_busy     = o_busy_reg;

endmodule
